fip_div_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined fixed-point divider (fip_32_div, 16.16, fully pipelined, fixed latency, one issue per cycle) among N_REQ requesters, such as the normalisation and intersection stages.
- Arbitrates requests and drives the divider's enable/operand ports.
- Tracks the requester ID of every in-flight operation in an in-order tag FIFO.
- Steers each divider result back to the requester that issued it.

---
 rtl/fip_pkg.sv | 30 +++
 rtl/fip_tag_fifo.sv | 54 +++++
 rtl/fip_div_sched.sv | 156 +++++++++++++++
 tb/tb_fip_div_sched.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fip_pkg.sv
// Shared 16.16 fixed-point types and divider tag layout.
// FIP_DIV_ZERO_SAT_EN adds divide-by-zero flags to the tag.
package fip_pkg;

    typedef logic signed [31:0] fip_t;

    localparam int   FRA_BITS = 16;
    localparam fip_t FIP_MIN  = 32'sh80000000;
    localparam fip_t FIP_MAX  = 32'sh7fffffff;
    localparam fip_t FIP_ONE  = fip_t'(1) <<< FRA_BITS;

    localparam int TAG_ID_W = 3;

`ifdef FIP_DIV_ZERO_SAT_EN
    typedef struct packed {
        logic [TAG_ID_W-1:0] id;
        logic                zero;
        logic                sign;
    } div_tag_t;
`else
    typedef struct packed {
        logic [TAG_ID_W-1:0] id;
    } div_tag_t;
`endif

    function automatic fip_t fip_sat(input logic sign);
        return sign ? FIP_MIN : FIP_MAX;
    endfunction

endpackage

// File: rtl/fip_tag_fifo.sv
// In-order circular FIFO of divider tags with occupancy counter.
// Push and pop may occur in the same cycle.
module fip_tag_fifo
    import fip_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  div_tag_t push_tag,
    input  logic     pop,
    output div_tag_t head,
    output logic     empty,
    output logic     full_thr
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    div_tag_t      mem_q [DEPTH];

    always_comb begin
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: only entries below the count are read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_tag;
        end
    end

    assign head     = mem_q[rd_q];
    assign empty    = (cnt_q == '0);
    assign full_thr = (cnt_q >= (AW+1)'(DEPTH - 1));

endmodule

// File: rtl/fip_div_sched.sv
// Round-robin scheduler sharing one pipelined 16.16 divider.
// FIP_DIV_ZERO_SAT_EN saturates divide-by-zero results.
module fip_div_sched
    import fip_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DIV_LATENCY = 50,
    parameter int TAG_DEPTH   = 64,
    parameter int ID_W        = $clog2(N_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [N_REQ*32-1:0] i_req_x,
    input  logic [N_REQ*32-1:0] i_req_y,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic               o_div_en,
    output logic [31:0]        o_div_x,
    output logic [31:0]        o_div_y,
    input  logic [31:0]        i_div_z,
    input  logic               i_div_valid,
    output logic [N_REQ-1:0]   o_rsp_valid,
    output logic [31:0]        o_rsp_z,
    output logic               o_busy,
    output logic               o_err
);

    if (TAG_DEPTH < DIV_LATENCY + 1 || N_REQ < 2 || N_REQ > 8) begin : g_bad_cfg
        $error("fip_div_sched: unsupported parameter set");
    end

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_id;
    logic             accept;
    fip_t             x_sel, y_sel;

    logic             full_thr, empty, pop;
    div_tag_t         head, push_tag;

    logic             div_en_q, div_en_d;
    fip_t             div_x_q, div_x_d;
    fip_t             div_y_q, div_y_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    fip_t             rsp_z_q, rsp_z_d;
    logic             err_q, err_d;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        logic [ID_W:0] idx;
        idx       = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_REQ)) begin
                idx = idx - (ID_W+1)'(N_REQ);
            end
            if (!gnt_found && i_req_valid[idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = idx[ID_W-1:0];
            end
        end
    end

    assign accept = gnt_found && !full_thr;
    assign x_sel  = i_req_x[32*int'(gnt_id) +: 32];
    assign y_sel  = i_req_y[32*int'(gnt_id) +: 32];
    assign pop    = i_div_valid && !empty;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            o_req_ready[k] = accept && (gnt_id == ID_W'(k));
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        div_en_d = accept;
        div_x_d  = div_x_q;
        div_y_d  = div_y_q;
        push_tag = '0;
        push_tag.id = TAG_ID_W'(gnt_id);
        if (accept) begin
            ptr_d   = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
            div_x_d = x_sel;
            div_y_d = y_sel;
`ifdef FIP_DIV_ZERO_SAT_EN
            // Zero divisors still occupy a slot so ordering is preserved.
            push_tag.zero = (y_sel == '0);
            push_tag.sign = x_sel[31];
            if (y_sel == '0) begin
                div_y_d = FIP_ONE;
            end
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            rsp_valid_d[k] = pop && (head.id == TAG_ID_W'(k));
        end
        rsp_z_d = rsp_z_q;
        if (pop) begin
            rsp_z_d = i_div_z;
`ifdef FIP_DIV_ZERO_SAT_EN
            if (head.zero) begin
                rsp_z_d = fip_sat(head.sign);
            end
`endif
        end
        err_d = err_q || (i_div_valid && empty);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q       <= '0;
            div_en_q    <= 1'b0;
            div_x_q     <= '0;
            div_y_q     <= '0;
            rsp_valid_q <= '0;
            rsp_z_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            div_en_q    <= div_en_d;
            div_x_q     <= div_x_d;
            div_y_q     <= div_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            err_q       <= err_d;
        end
    end

    fip_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .push     (accept),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .full_thr (full_thr)
    );

    assign o_div_en    = div_en_q;
    assign o_div_x     = div_x_q;
    assign o_div_y     = div_y_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_z     = rsp_z_q;
    assign o_busy      = !empty;
    assign o_err       = err_q;

endmodule

// File: tb/tb_fip_div_sched.sv
// Scoreboard bench for fip_div_sched with a fixed-latency divider model.
// Honours FIP_DIV_ZERO_SAT_EN for the divide-by-zero cases.
module tb_fip_div_sched;

    localparam int N     = 4;
    localparam int LAT   = 50;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*32-1:0]   req_x, req_y;
    logic [N-1:0]      req_ready;
    logic              div_en;
    logic [31:0]       div_x, div_y, div_z;
    logic              div_valid;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_z;
    logic              busy, err;

    fip_div_sched #(
        .N_REQ       (N),
        .DIV_LATENCY (LAT),
        .TAG_DEPTH   (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_x     (req_x),
        .i_req_y     (req_y),
        .o_req_ready (req_ready),
        .o_div_en    (div_en),
        .o_div_x     (div_x),
        .o_div_y     (div_y),
        .i_div_z     (div_z),
        .i_div_valid (div_valid),
        .o_rsp_valid (rsp_valid),
        .o_rsp_z     (rsp_z),
        .o_busy      (busy),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] z;
        longint      due;
    } exp_t;

    typedef struct {
        logic [31:0] z;
        longint      due;
    } div_t;

    exp_t        expq[$];
    div_t        divq[$];
    exp_t        mon_e;

    int          passes = 0;
    int          total  = 0;

    int          m_ptr = 0;
    int          m_cnt = 0;
    bit          m_err = 0;
    bit          last_acc = 0;
    logic [31:0] last_x = '0, last_y = '0;
    bit          stall = 0;
    int          release_n = 0;
    bit          lat_known = 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                      name, act, exp, cyc);
    endtask

    // Plain 16.16 quotient, truncated toward zero.
    function automatic logic [31:0] fdiv(input logic [31:0] x,
                                         input logic [31:0] y);
        longint xs, ys, q;
        if (y == 0) return 32'h0;
        xs = longint'($signed(x));
        ys = longint'($signed(y));
        q  = (xs * 65536) / ys;
        return q[31:0];
    endfunction

    function automatic logic [31:0] ref_z(input logic [31:0] x,
                                          input logic [31:0] y);
`ifdef FIP_DIV_ZERO_SAT_EN
        if (y == 0) return x[31] ? 32'h80000000 : 32'h7fffffff;
`endif
        return fdiv(x, y);
    endfunction

    function automatic logic [N*32-1:0] rnd_ops(input bit allow_zero);
        logic [N*32-1:0] r;
        logic [31:0]     v;
        r = '0;
        for (int k = 0; k < N; k++) begin
            v = $urandom;
            if (allow_zero && $urandom_range(0, 7) == 0) v = 0;
            else if (v == 0) v = 1;
            r[k*32 +: 32] = v;
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard whenever a response pulse appears.
    always @(negedge clk) begin
        if (!rst) begin
            while (expq.size() > 0 && expq[0].due >= 0 && expq[0].due < cyc) begin
                check("rsp_latency", cyc, expq[0].due);
                void'(expq.pop_front());
            end
            if (|rsp_valid) begin
                if (expq.size() == 0) begin
                    check("stale_rsp", rsp_valid, 0);
                end else begin
                    mon_e = expq.pop_front();
                    check("rsp_id", rsp_valid, 64'(1) << mon_e.id);
                    check("rsp_z", rsp_z, mon_e.z);
                    if (mon_e.due >= 0) check("rsp_latency", cyc, mon_e.due);
                end
            end
        end
    end

    task automatic cycle(input logic [N-1:0] vm, input logic [N*32-1:0] xs,
                         input logic [N*32-1:0] ys, input bit err_pulse);
        int          g;
        bit          pop;
        logic [31:0] xv, yv;
        div_t        d;
        @(negedge clk);
        check("div_en", div_en, last_acc);
        if (last_acc) begin
            check("div_x", div_x, last_x);
            check("div_y", div_y, last_y);
        end
        check("busy", busy, m_cnt > 0);
        check("err", err, m_err);
        if (div_en) divq.push_back('{fdiv(div_x, div_y), cyc + LAT});
        div_valid = 1'b0;
        div_z     = '0;
        if (err_pulse) begin
            div_valid = 1'b1;
            div_z     = $urandom;
        end else if (divq.size() > 0 && divq[0].due <= cyc &&
                     (!stall || release_n > 0)) begin
            d         = divq.pop_front();
            div_valid = 1'b1;
            div_z     = d.z;
            if (stall) release_n--;
        end
        req_valid = vm;
        req_x     = xs;
        req_y     = ys;
        #1;
        g = -1;
        if (m_cnt < DEPTH - 1) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && vm[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
        end
        check("req_ready", req_ready, (g >= 0) ? (64'(1) << g) : 64'(0));
        pop = div_valid && m_cnt > 0;
        if (div_valid && m_cnt == 0) m_err = 1;
        last_acc = 0;
        if (g >= 0) begin
            xv = xs[g*32 +: 32];
            yv = ys[g*32 +: 32];
            expq.push_back('{g, ref_z(xv, yv), lat_known ? cyc + LAT + 2 : -1});
            m_ptr    = (g + 1) % N;
            last_acc = 1;
            last_x   = xv;
            last_y   = yv;
`ifdef FIP_DIV_ZERO_SAT_EN
            if (yv == 0) last_y = 32'h00010000;
`endif
        end
        m_cnt = m_cnt + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_div_en", div_en, 0);
        check("rst_div_x", div_x, 0);
        check("rst_div_y", div_y, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_z", rsp_z, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
    endtask

    task automatic model_reset();
        expq.delete();
        divq.delete();
        m_ptr    = 0;
        m_cnt    = 0;
        m_err    = 0;
        last_acc = 0;
    endtask

    logic [N*32-1:0] xs, ys;
    int              guard;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        div_valid = 1'b0;
        div_z     = '0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Single request from requester 2: 3.0 / 2.0 = 1.5.
        xs = '0; ys = '0;
        xs[2*32 +: 32] = 32'h00030000;
        ys[2*32 +: 32] = 32'h00020000;
        cycle(4'b0100, xs, ys, 1'b0);
        idle(60);

        // All requesters valid: grants rotate, responses back-to-back.
        for (int i = 0; i < 8; i++) cycle(4'hf, rnd_ops(0), rnd_ops(0), 1'b0);
        idle(60);

        // Negative dividend: -1.0 / 4.0 = -0.25.
        xs = rnd_ops(0); ys = rnd_ops(0);
        xs[1*32 +: 32] = 32'hFFFF0000;
        ys[1*32 +: 32] = 32'h00040000;
        cycle(4'b0010, xs, ys, 1'b0);
`ifdef FIP_DIV_ZERO_SAT_EN
        ys[1*32 +: 32] = 32'h0;
        cycle(4'b0010, xs, ys, 1'b0);
        xs[3*32 +: 32] = 32'h00050000;
        ys[3*32 +: 32] = 32'h0;
        cycle(4'b1000, xs, ys, 1'b0);
`endif
        idle(60);

        // Random traffic with random request masks.
        for (int i = 0; i < 300; i++) begin
`ifdef FIP_DIV_ZERO_SAT_EN
            cycle(N'($urandom), rnd_ops(0), rnd_ops(1), 1'b0);
`else
            cycle(N'($urandom), rnd_ops(0), rnd_ops(0), 1'b0);
`endif
        end
        idle(60);

        // Stalled returns: fill to the threshold, then free one slot.
        stall     = 1;
        lat_known = 0;
        guard     = 0;
        while (m_cnt < DEPTH - 1 && guard < 200) begin
            cycle(4'hf, rnd_ops(0), rnd_ops(0), 1'b0);
            guard++;
        end
        check("fill_reached", busy && (guard < 200), 1);
        for (int i = 0; i < 5; i++) cycle(4'hf, rnd_ops(0), rnd_ops(0), 1'b0);
        release_n = 1;
        for (int i = 0; i < 4; i++) cycle(4'hf, rnd_ops(0), rnd_ops(0), 1'b0);
        stall = 0;
        idle(120);
        lat_known = 1;

        // Reset with about 25 operations in flight.
        for (int i = 0; i < 25; i++) cycle(4'hf, rnd_ops(0), rnd_ops(0), 1'b0);
        @(negedge clk);
        #2;
        rst       = 1'b1;
        req_valid = '0;
        div_valid = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(70);
        for (int i = 0; i < 12; i++) cycle(N'($urandom), rnd_ops(0), rnd_ops(0), 1'b0);
        idle(60);

        // Stray divider result with nothing in flight.
        cycle('0, '0, '0, 1'b1);
        idle(6);

        check("scoreboard_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
